// File: rtl/spi_reg_host.sv
// Host-side SPI mode-0 master: one start request becomes a 16-bit frame (command byte, data byte)
// and returns the status and data bytes shifted in from the register slave.
module spi_reg_host #(
  parameter int ADDR_W      = 3,
  parameter int REG_W       = 8,
  parameter int HALF_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic [REG_W-1:0]  status,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = 2 * REG_W;
  localparam int HCNT_W  = $clog2(HALF_PERIOD);
  localparam int BCNT_W  = $clog2(FRAME_W);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HALF_PERIOD - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [FRAME_W-1:0]  rx_q, rx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic [REG_W-1:0]    rdata_q, rdata_d;
  logic [REG_W-1:0]    status_q, status_d;
  logic [REG_W-1:0]    cmd_byte;
  logic [REG_W-1:0]    data_byte;
  logic                last_half;

  assign last_half = (hcnt_q == HCNT_LAST);

  // Reads transmit a zero data byte regardless of wdata.
  always_comb begin
    cmd_byte               = '0;
    cmd_byte[REG_W-1]      = rw;
    cmd_byte[ADDR_W-1:0]   = addr;
    data_byte              = rw ? wdata : '0;
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = last_half ? '0 : hcnt_q + 1'b1;
    bcnt_d   = bcnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (start) begin
          state_d = SETUP;
          tx_d    = {cmd_byte, data_byte};
          mosi_d  = cmd_byte[REG_W-1];
          bcnt_d  = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
        end
      end
      SETUP, SHIFT_LO: begin
        if (last_half) begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[FRAME_W-2:0], spi_miso};
        end
      end
      SHIFT_HI: begin
        if (last_half) begin
          sclk_d = 1'b0;
          if (bcnt_q == BCNT_LAST) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
            bcnt_d  = '0;
          end else begin
            state_d = SHIFT_LO;
            mosi_d  = tx_q[FRAME_W-2];
            tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
            bcnt_d  = bcnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (last_half) begin
          state_d  = GAP;
          cs_n_d   = 1'b1;
          done_d   = 1'b1;
          status_d = rx_q[FRAME_W-1:REG_W];
          rdata_d  = rx_q[REG_W-1:0];
        end
      end
      GAP: begin
        if (last_half) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      rdata_q  <= '0;
      status_q <= '0;
    end else if (ena) begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign status   = status_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_reg_host.sv
// Scoreboard bench for spi_reg_host: a frame-level slave model feeds MISO, expected results
// are queued at issue time and checked by monitors when done pulses.
module tb_spi_reg_host;
  localparam int AW = 3;
  localparam int H  = 4;
  localparam int H6 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstb, ena;
  logic          start, rw;
  logic [AW-1:0] addr;
  logic [7:0]    wdata, rdata, status;
  logic          busy, done, sclk, cs_n, mosi, miso;

  logic          start6, rw6;
  logic [AW-1:0] addr6;
  logic [7:0]    wdata6, rdata6, status6;
  logic          busy6, done6, sclk6, cs_n6, mosi6, miso6;

  spi_reg_host #(.ADDR_W(AW), .REG_W(8), .HALF_PERIOD(H)) u_dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .status(status),
    .spi_clk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso)
  );

  spi_reg_host #(.ADDR_W(AW), .REG_W(8), .HALF_PERIOD(H6)) u_dut6 (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start6), .rw(rw6), .addr(addr6), .wdata(wdata6),
    .busy(busy6), .done(done6), .rdata(rdata6), .status(status6),
    .spi_clk(sclk6), .spi_cs_n(cs_n6), .spi_mosi(mosi6), .spi_miso(miso6)
  );

  // Loopback slave for the H=6 instance: it returns exactly what it receives.
  assign miso6 = mosi6;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ecyc   = 0;
  int busy_until = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ena) ecyc <= ecyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [15:0] mosi;
    logic [7:0]  st;
    logic [7:0]  rd;
    int          ecyc_done;
    int          cyc_done;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp6_q[$];

  // Slave model for the H=4 instance: presents one response word per frame, MSB first,
  // and records what the master shifted out on MOSI.
  logic [15:0] resp, resp_lat, mcap;
  int          nfall, nrise;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0;

  initial miso = 1'b0;

  always @(negedge clk) begin
    if (cs_prev && !cs_n) begin
      nfall = 0;
      nrise = 0;
      mcap = '0;
      resp_lat = resp;
    end else if (!cs_n) begin
      if (!sclk_prev && sclk) begin
        mcap = {mcap[14:0], mosi};
        nrise++;
      end
      if (sclk_prev && !sclk) nfall++;
    end
    miso = (!cs_n && nfall < 16) ? resp_lat[15 - nfall] : 1'b0;
    cs_prev = cs_n;
    sclk_prev = sclk;
  end

  // Monitor for the H=4 instance.
  exp_t mon_e;
  logic busy_prev = 1'b0;
  bit   bf_pending = 0;
  int   bf_exp = 0;

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mosi_frame", mcap, mon_e.mosi);
        chk("status", status, mon_e.st);
        chk("rdata", rdata, mon_e.rd);
        chk("sclk_rises", nrise, 16);
        chk("done_ena_cycles", ecyc, mon_e.ecyc_done);
        chk("done_cycle", cyc, mon_e.cyc_done);
        chk("busy_with_done", busy, 1);
        bf_pending = 1;
        bf_exp = mon_e.ecyc_done + H;
      end
    end
    if (busy_prev && !busy && bf_pending) begin
      chk("busy_fall_cycle", ecyc, bf_exp);
      bf_pending = 0;
    end
    busy_prev = busy;
  end

  // Monitor for the H=6 instance: results plus the idle spacing between frames.
  logic [15:0] mon6;
  int   dcount6 = 0;
  int   cs_hi = 0, sclk_lo = 0;
  bit   seen6 = 0, first_rise = 0;
  logic cs6_prev = 1'b1, sclk6_prev = 1'b0;

  always @(negedge clk) begin
    if (done6) begin
      if (exp6_q.size() == 0) begin
        chk("done6_unexpected", 1, 0);
      end else begin
        mon6 = exp6_q.pop_front();
        chk("status6", status6, mon6[15:8]);
        chk("rdata6", rdata6, mon6[7:0]);
        dcount6++;
      end
    end
    if (cs6_prev && !cs_n6) begin
      if (seen6) begin
        chk("cs6_high_gap", cs_hi, H6 + 1);
        first_rise = 1;
      end
      seen6 = 1;
    end
    if (!sclk6_prev && sclk6) begin
      if (first_rise) chk("sclk6_quiet_ge_2H", (sclk_lo >= 2 * H6), 1);
      first_rise = 0;
      sclk_lo = 0;
    end
    if (cs_n6) cs_hi++; else cs_hi = 0;
    if (!sclk6) sclk_lo++;
    cs6_prev = cs_n6;
    sclk6_prev = sclk6;
  end

  // Reference model: a start is taken only when enabled and the previous frame's
  // 34 half-period budget (in enabled cycles) has elapsed.
  task automatic issue(input logic r, input logic [AW-1:0] a, input logic [7:0] wd,
                       input logic [7:0] st, input logic [7:0] dt,
                       input bit expect_done, input int stall);
    exp_t e;
    bit   acc;
    @(negedge clk);
    acc = ena && (ecyc >= busy_until);
    start = 1'b1; rw = r; addr = a; wdata = wd;
    if (acc) begin
      resp = {st, dt};
      busy_until = ecyc + 1 + 34 * H;
      if (expect_done) begin
        e.mosi      = 16'((r * 128 + a) * 256 + (r ? wd : 0));
        e.st        = st;
        e.rd        = dt;
        e.ecyc_done = ecyc + 1 + 33 * H;
        e.cyc_done  = cyc + 1 + 33 * H + stall;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_free();
    while (ecyc < busy_until) @(negedge clk);
  endtask

  logic s_clk, s_cs, s_mosi;
  int   n;

  initial begin
    rstb = 1'b0; ena = 1'b1;
    start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; resp = '0; resp_lat = '0;
    start6 = 1'b0; rw6 = 1'b0; addr6 = '0; wdata6 = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_status", status, 0);
    chk("rst_cs_n6", cs_n6, 1);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Write, read, then a start pulsed into an active frame.
    issue(1'b1, 3'd5, 8'hA5, 8'h3C, 8'($urandom), 1, 0);
    wait_free();
    issue(1'b0, 3'd2, 8'hC3, 8'h11, 8'h5A, 1, 0);
    wait_free();
    issue(1'b1, 3'd4, 8'h69, 8'($urandom), 8'($urandom), 1, 0);
    repeat (9) @(negedge clk);
    issue(1'($urandom), 3'd7, 8'($urandom), 8'($urandom), 8'($urandom), 1, 0);
    wait_free();

    // Clock enable dropped for 20 cycles mid-frame.
    issue(1'b1, 3'd5, 8'hA5, 8'h3C, 8'h96, 1, 20);
    repeat (30) @(negedge clk);
    ena = 1'b0;
    s_clk = sclk; s_cs = cs_n; s_mosi = mosi;
    repeat (20) begin
      @(negedge clk);
      chk("stall_sclk", sclk, s_clk);
      chk("stall_cs_n", cs_n, s_cs);
      chk("stall_mosi", mosi, s_mosi);
    end
    ena = 1'b1;
    wait_free();

    // Start while disabled is dropped.
    ena = 1'b0;
    issue(1'b1, 3'd6, 8'h33, 8'h00, 8'h00, 1, 0);
    repeat (3) @(negedge clk);
    chk("ena_low_start_ignored", busy, 0);
    ena = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset at bit 6, then a normal write.
    issue(1'b1, 3'd3, 8'h77, 8'h12, 8'h34, 0, 0);
    repeat (52) @(negedge clk);
    chk("pre_abort_cs_n", cs_n, 0);
    rstb = 1'b0;
    busy_until = 0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mosi", mosi, 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    issue(1'b1, 3'd1, 8'hFF, 8'($urandom), 8'($urandom), 1, 0);
    wait_free();

    // Randomized traffic; starts landing mid-frame are dropped by the model.
    repeat (25) begin
      repeat ($urandom_range(0, 34 * H + 8)) @(negedge clk);
      issue(1'($urandom), AW'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, 0);
    end
    wait_free();

    // H=6 back-to-back: restart on the cycle after busy falls.
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      rw6 = 1'($urandom); addr6 = AW'($urandom); wdata6 = 8'($urandom);
      start6 = 1'b1;
      exp6_q.push_back({8'(rw6 * 128 + addr6), (rw6 ? wdata6 : 8'h00)});
      @(negedge clk);
      start6 = 1'b0;
      n = 0;
      while (busy6 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) chk("busy6_timeout", 1, 0);
    end
    repeat (4) @(negedge clk);
    chk("done6_count", dcount6, 3);

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp6_q_drained", exp6_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
